// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file port arbiter.
// Holds the arbiter FSM encoding and the register-file geometry.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DBG_WR = 2'd1,
        DBG_RD = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/regfile_port_arbiter_if.sv
// Debug-host request/response channel into the register-file port arbiter.
// The host drives the request fields; the arbiter answers with ack and read data.
interface regfile_port_arbiter_if #(
    parameter int ADDR_W = regfile_pkg::REG_ADDR_W,
    parameter int DATA_W = regfile_pkg::REG_DATA_W
);
    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_rdata;

    modport master (
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_ack, dbg_rdata
    );

    modport slave (
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_ack, dbg_rdata
    );
endinterface

// File: rtl/regfile_port_arbiter.sv
// Shares the register file's write port and read port 1 between the core and a
// debug host; the core has priority, and a starvation counter forces a debug grant.
module regfile_port_arbiter
    import regfile_pkg::*;
#(
    parameter int ADDR_W     = REG_ADDR_W,
    parameter int DATA_W     = REG_DATA_W,
    parameter int STARVE_MAX = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   core_we,
    input  logic                   core_ren,
    input  logic [ADDR_W-1:0]      core_a1,
    input  logic [ADDR_W-1:0]      core_a3,
    input  logic [DATA_W-1:0]      core_wd,
    output logic                   core_stall,
    regfile_port_arbiter_if.slave  dbg,
    output logic [ADDR_W-1:0]      rf_a1,
    input  logic [DATA_W-1:0]      rf_rd1,
    output logic [ADDR_W-1:0]      rf_a3,
    output logic [DATA_W-1:0]      rf_wd,
    output logic                   rf_we
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    arb_state_t        state, state_nxt;
    logic [CNT_W-1:0]  wait_cnt, wait_nxt;
    logic [DATA_W-1:0] rdata_q;
    logic              ack_c;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            rdata_q  <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (state == DBG_RD)
                rdata_q <= rf_rd1;
        end
    end

    // Grant when the core leaves both ports free, or when the host has waited too long.
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        case (state)
            IDLE: begin
                if (dbg.dbg_req) begin
                    if ((!core_we && !core_ren) || (wait_cnt == CNT_MAX)) begin
                        wait_nxt  = '0;
                        state_nxt = dbg.dbg_we ? DBG_WR : DBG_RD;
                    end else begin
                        wait_nxt = sat_inc(wait_cnt);
                    end
                end else begin
                    wait_nxt = '0;
                end
            end
            DBG_WR, DBG_RD: state_nxt = DONE;
            DONE:           state_nxt = IDLE;
            default:        state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rf_a1      = core_a1;
        rf_a3      = core_a3;
        rf_wd      = core_wd;
        rf_we      = core_we;
        core_stall = 1'b0;
        ack_c      = 1'b0;
        case (state)
            DBG_WR: begin
                rf_a3      = dbg.dbg_addr;
                rf_wd      = dbg.dbg_wdata;
                rf_we      = (dbg.dbg_addr != ADDR_W'(REG_ZERO));
                core_stall = 1'b1;
            end
            DBG_RD: begin
                rf_a1      = dbg.dbg_addr;
                rf_we      = 1'b0;
                core_stall = 1'b1;
            end
            DONE:    ack_c = 1'b1;
            default: ;
        endcase
        // A reset landing before the falling edge must drop an in-flight write.
        if (rst)
            rf_we = 1'b0;
    end

    assign dbg.dbg_ack   = ack_c;
    assign dbg.dbg_rdata = rdata_q;

    a_req_held: assert property (@(posedge clk) disable iff (rst)
        (state == DBG_WR || state == DBG_RD) |-> dbg.dbg_req)
        else $error("dbg_req dropped before dbg_ack");

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a behavioural 32x32 register file
// that writes on the falling clock edge and masks address 0.
module tb_regfile_port_arbiter;
    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_we, core_ren;
    logic [4:0]  core_a1, core_a3;
    logic [31:0] core_wd;
    logic        core_stall;
    logic [4:0]  rf_a1, rf_a3;
    logic [31:0] rf_rd1, rf_wd;
    logic        rf_we;

    int total = 0;
    int bad   = 0;

    regfile_port_arbiter_if dbg_if ();

    regfile_port_arbiter #(.ADDR_W(5), .DATA_W(32), .STARVE_MAX(15)) dut (
        .clk        (clk),
        .rst        (rst),
        .core_we    (core_we),
        .core_ren   (core_ren),
        .core_a1    (core_a1),
        .core_a3    (core_a3),
        .core_wd    (core_wd),
        .core_stall (core_stall),
        .dbg        (dbg_if.slave),
        .rf_a1      (rf_a1),
        .rf_rd1     (rf_rd1),
        .rf_a3      (rf_a3),
        .rf_wd      (rf_wd),
        .rf_we      (rf_we)
    );

    always #5 clk = ~clk;

    logic [31:0] regs [32];
    always @(negedge clk)
        if (rf_we && rf_a3 != 5'd0) regs[rf_a3] <= rf_wd;
    assign rf_rd1 = (rf_a1 == 5'd0) ? 32'd0 : regs[rf_a1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dbg_set(input logic req, input logic we, input logic [4:0] addr,
                           input logic [31:0] wd);
        dbg_if.dbg_req   = req;
        dbg_if.dbg_we    = we;
        dbg_if.dbg_addr  = addr;
        dbg_if.dbg_wdata = wd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        core_we = 1'b1; core_ren = 1'b0;
        core_a1 = 5'd5; core_a3 = 5'd9; core_wd = 32'h0;
        dbg_set(1'b0, 1'b0, 5'd0, 32'h0);
        tick(); tick();
        #2;
        // reset state
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        chk("rst_wait", 32'(dut.wait_cnt), 32'd0);
        chk("rst_ack", 32'(dbg_if.dbg_ack), 32'd0);
        chk("rst_rdata", dbg_if.dbg_rdata, 32'd0);
        chk("rst_stall", 32'(core_stall), 32'd0);
        chk("rst_rfwe", 32'(rf_we), 32'd0);
        chk("rst_rfa1", 32'(rf_a1), 32'd5);
        chk("rst_rfa3", 32'(rf_a3), 32'd9);

        tick();
        rst = 1'b0; core_we = 1'b0;
        tick();

        // debug write DEADBEEF to r7, idle core
        dbg_set(1'b1, 1'b1, 5'd7, 32'hDEADBEEF);
        #2;
        chk("w7_req_state", 32'(dut.state), 32'(IDLE));
        chk("w7_req_stall", 32'(core_stall), 32'd0);
        tick(); #2;
        chk("w7_grant_state", 32'(dut.state), 32'(DBG_WR));
        chk("w7_grant_stall", 32'(core_stall), 32'd1);
        chk("w7_rfwe", 32'(rf_we), 32'd1);
        chk("w7_rfa3", 32'(rf_a3), 32'd7);
        chk("w7_rfwd", rf_wd, 32'hDEADBEEF);
        chk("w7_noack", 32'(dbg_if.dbg_ack), 32'd0);
        tick();
        dbg_if.dbg_req = 1'b0;
        core_ren = 1'b1; core_a1 = 5'd7;
        #2;
        chk("w7_ack", 32'(dbg_if.dbg_ack), 32'd1);
        chk("w7_done_stall", 32'(core_stall), 32'd0);
        chk("w7_core_read", rf_rd1, 32'hDEADBEEF);
        tick();
        core_ren = 1'b0;
        #2;
        chk("w7_ack_gone", 32'(dbg_if.dbg_ack), 32'd0);

        // debug read r7, idle core
        dbg_set(1'b1, 1'b0, 5'd7, 32'h0);
        tick(); #2;
        chk("r7_state", 32'(dut.state), 32'(DBG_RD));
        chk("r7_stall", 32'(core_stall), 32'd1);
        chk("r7_rfa1", 32'(rf_a1), 32'd7);
        chk("r7_rfwe", 32'(rf_we), 32'd0);
        tick();
        dbg_if.dbg_req = 1'b0;
        #2;
        chk("r7_ack", 32'(dbg_if.dbg_ack), 32'd1);
        chk("r7_rdata", dbg_if.dbg_rdata, 32'hDEADBEEF);
        chk("r7_stall_off", 32'(core_stall), 32'd0);
        tick();

        // busy core writing r3 every cycle, debug read of r3 starves then is forced
        core_we = 1'b1; core_a3 = 5'd3; core_wd = 32'h0000_0033;
        dbg_set(1'b1, 1'b0, 5'd3, 32'h0);
        for (int i = 0; i < 15; i++) begin
            #2;
            chk($sformatf("starve_wait%0d", i), 32'(dut.wait_cnt), 32'(i));
            chk($sformatf("starve_stall%0d", i), 32'(core_stall), 32'd0);
            tick();
        end
        #2;
        chk("starve_sat", 32'(dut.wait_cnt), 32'd15);
        chk("starve_last_idle", 32'(dut.state), 32'(IDLE));
        chk("starve_core_we", 32'(rf_we), 32'd1);
        tick(); #2;
        chk("starve_grant", 32'(dut.state), 32'(DBG_RD));
        chk("starve_stall", 32'(core_stall), 32'd1);
        chk("starve_clear", 32'(dut.wait_cnt), 32'd0);
        chk("starve_we_off", 32'(rf_we), 32'd0);
        tick();
        dbg_if.dbg_req = 1'b0; core_we = 1'b0;
        #2;
        chk("starve_ack", 32'(dbg_if.dbg_ack), 32'd1);
        chk("starve_rdata", dbg_if.dbg_rdata, 32'h0000_0033);
        chk("starve_stall_off", 32'(core_stall), 32'd0);
        tick();

        // debug write to r0 is suppressed but acknowledged; read of r0 returns 0
        dbg_set(1'b1, 1'b1, 5'd0, 32'h0000_1234);
        tick(); #2;
        chk("w0_stall", 32'(core_stall), 32'd1);
        chk("w0_rfwe", 32'(rf_we), 32'd0);
        tick();
        dbg_if.dbg_req = 1'b0;
        #2;
        chk("w0_ack", 32'(dbg_if.dbg_ack), 32'd1);
        tick();
        dbg_set(1'b1, 1'b0, 5'd0, 32'h0);
        tick(); tick();
        dbg_if.dbg_req = 1'b0;
        #2;
        chk("r0_ack", 32'(dbg_if.dbg_ack), 32'd1);
        chk("r0_rdata", dbg_if.dbg_rdata, 32'd0);
        tick();

        // back-to-back requests with req held: acks 3 cycles apart
        dbg_set(1'b1, 1'b0, 5'd7, 32'h0);
        for (int i = 0; i < 6; i++) begin
            #2;
            chk($sformatf("b2b_ack%0d", i), 32'(dbg_if.dbg_ack), (i == 2 || i == 5) ? 32'd1 : 32'd0);
            chk($sformatf("b2b_stall%0d", i), 32'(core_stall), (i == 1 || i == 4) ? 32'd1 : 32'd0);
            if (i == 5) dbg_if.dbg_req = 1'b0;
            tick();
        end

        // reset during DBG_WR before the falling edge drops the write
        dbg_set(1'b1, 1'b1, 5'd7, 32'hCAFEF00D);
        tick();
        #1;
        chk("rstmid_in_wr", 32'(dut.state), 32'(DBG_WR));
        rst = 1'b1;
        dbg_if.dbg_req = 1'b0;
        #1;
        chk("rstmid_state", 32'(dut.state), 32'(IDLE));
        chk("rstmid_rfwe", 32'(rf_we), 32'd0);
        chk("rstmid_stall", 32'(core_stall), 32'd0);
        chk("rstmid_ack", 32'(dbg_if.dbg_ack), 32'd0);
        chk("rstmid_wait", 32'(dut.wait_cnt), 32'd0);
        chk("rstmid_rdata", dbg_if.dbg_rdata, 32'd0);
        tick();
        rst = 1'b0;
        core_ren = 1'b1; core_a1 = 5'd7;
        #2;
        chk("rstmid_r7_kept", rf_rd1, 32'hDEADBEEF);
        tick(); #2;
        chk("rstmid_no_ack", 32'(dbg_if.dbg_ack), 32'd0);
        chk("rstmid_idle", 32'(dut.state), 32'(IDLE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
